// File: rtl/stage3_pool_streamer_pkg.sv
// Shared sizing and state encoding for the stage-3 pooled-frame streamer.
// CI/OF_BW/W_BW mirror the stage-3 core header; POS/CO fix the frame and filter counts.
package stage3_pool_streamer_pkg;

   localparam int S3_CI    = 4;
   localparam int S3_OF_BW = 8;
   localparam int S3_W_BW  = 8;
   localparam int S3_POS   = 16;
   localparam int S3_CO    = 4;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Counter width that stays legal when a dimension collapses to 1.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stage3_pool_streamer_pingpong_ram.sv
// Two-bank frame store: one write port, one synchronous read port.
// Contents are never reset; validity is tracked by the owner's bank_full flags.
module stage3_pingpong_ram
   import stage3_pool_streamer_pkg::*;
#(
   parameter int DEPTH = S3_POS,
   parameter int DW    = S3_CI * S3_OF_BW
)(
   input  logic                    clk,
   input  logic                    i_wr_en,
   input  logic                    i_wr_bank,
   input  logic [cnt_w(DEPTH)-1:0] i_wr_addr,
   input  logic [DW-1:0]           i_wr_data,
   input  logic                    i_rd_en,
   input  logic                    i_rd_bank,
   input  logic [cnt_w(DEPTH)-1:0] i_rd_addr,
   output logic [DW-1:0]           o_rd_data
);

   logic [DW-1:0] r_mem [2][DEPTH];
   logic [DW-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en)
         r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
      if (i_rd_en)
         r_rd_data <= r_mem[i_rd_bank][i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/stage3_pool_streamer.sv
// Captures pooled frames into a ping-pong buffer and replays each frame once per
// output filter, pairing every vector with its weight-ROM word for the stage-3 kernel.
module stage3_pool_streamer
   import stage3_pool_streamer_pkg::*;
#(
   parameter int CI    = S3_CI,
   parameter int OF_BW = S3_OF_BW,
   parameter int W_BW  = S3_W_BW,
   parameter int POS   = S3_POS,
   parameter int CO    = S3_CO,
   parameter int AW    = $clog2(CO * POS)
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_pool_valid,
   input  logic [CI*OF_BW-1:0]   i_pool_data,
   output logic                  o_pool_ready,
   output logic [AW-1:0]         o_w_addr,
   input  logic [CI*W_BW-1:0]    i_w_data,
   output logic                  o_pooling_valid,
   output logic [CI*OF_BW-1:0]   o_pooling,
   output logic [CI*W_BW-1:0]    o_weight,
   output logic                  o_first,
   output logic                  o_last,
   output logic [cnt_w(CO)-1:0]  o_filter_idx,
   output logic                  o_busy,
   output logic                  o_overflow
);

   localparam int DW = CI * OF_BW;
   localparam int PW = cnt_w(POS);
   localparam int KW = cnt_w(CO);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [1:0]      r_bank_full;
   logic [1:0]      w_set;
   logic [1:0]      w_clr;
   logic            r_wr_bank;
   logic            r_rd_bank;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_p;
   logic [PW-1:0]   w_p_nxt;
   logic [KW-1:0]   r_k;
   logic [KW-1:0]   w_k_nxt;
   logic            w_wr_acc;
   logic            w_wr_last;
   logic            w_issue;
   logic            w_release;
   logic            r_overflow;
   logic            r_vld_p1;
   logic            r_first_p1;
   logic            r_last_p1;
   logic [KW-1:0]   r_k_p1;
   logic [DW-1:0]   w_rd_data;

   assign o_pool_ready = ~r_bank_full[r_wr_bank];
   assign w_wr_acc     = i_pool_valid & o_pool_ready;
   assign w_wr_last    = w_wr_acc && (r_wr_ptr == PW'(POS - 1));

   // Fill and release always target different banks, so both may land in one cycle.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (w_wr_last)
         w_set[r_wr_bank] = 1'b1;
      if (w_release)
         w_clr[r_rd_bank] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_bank_full <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
            if (w_wr_last)
               r_wr_bank <= ~r_wr_bank;
         end
         if (i_pool_valid && !o_pool_ready)
            r_overflow <= 1'b1;
         r_bank_full <= (r_bank_full | w_set) & ~w_clr;
         if (w_release)
            r_rd_bank <= ~r_rd_bank;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_p     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         r_p     <= w_p_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_p_nxt     = r_p;
      w_issue     = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_bank_full[r_rd_bank]) begin
               w_state_nxt = S_RUN;
               w_k_nxt     = '0;
               w_p_nxt     = '0;
            end
         end
         S_RUN: begin
            w_issue = 1'b1;
            if (r_p == PW'(POS - 1)) begin
               w_p_nxt = '0;
               if (r_k == KW'(CO - 1)) begin
                  w_k_nxt   = '0;
                  w_release = 1'b1;
                  // Chain straight into the other bank when it is already loaded.
                  w_state_nxt = r_bank_full[~r_rd_bank] ? S_RUN : S_IDLE;
               end else begin
                  w_k_nxt = r_k + 1'b1;
               end
            end else begin
               w_p_nxt = r_p + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   stage3_pingpong_ram #(
      .DEPTH (POS),
      .DW    (DW)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_acc),
      .i_wr_bank (r_wr_bank),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (i_pool_data),
      .i_rd_en   (w_issue),
      .i_rd_bank (r_rd_bank),
      .i_rd_addr (r_p),
      .o_rd_data (w_rd_data)
   );

   // p1: beat tags delayed to meet the RAM read data and the ROM word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld_p1   <= 1'b0;
         r_first_p1 <= 1'b0;
         r_last_p1  <= 1'b0;
         r_k_p1     <= '0;
      end else begin
         r_vld_p1   <= w_issue;
         r_first_p1 <= w_issue && (r_p == '0);
         r_last_p1  <= w_issue && (r_p == PW'(POS - 1));
         r_k_p1     <= w_issue ? r_k : '0;
      end
   end

   assign o_w_addr        = w_issue ? (AW'(r_k) * AW'(POS) + AW'(r_p)) : '0;
   assign o_pooling_valid = r_vld_p1;
   // Stale RAM contents are masked so idle and reset show zero data.
   assign o_pooling       = r_vld_p1 ? w_rd_data : '0;
   assign o_weight        = i_w_data;
   assign o_first         = r_first_p1;
   assign o_last          = r_last_p1;
   assign o_filter_idx    = r_k_p1;
   assign o_busy          = (r_state == S_RUN);
   assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_stage3_pool_streamer.sv
// Directed and randomized checks of stage3_pool_streamer against a frame-replay model.
module tb_stage3_pool_streamer;

   localparam int CI  = 4;
   localparam int OFB = 8;
   localparam int WB  = 8;
   localparam int POS = 16;
   localparam int CO  = 4;
   localparam int AW  = 6;
   localparam int FB  = CO * POS;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              i_pool_valid = 1'b0;
   logic [CI*OFB-1:0] i_pool_data = '0;
   logic              o_pool_ready;
   logic [AW-1:0]     o_w_addr;
   logic [CI*WB-1:0]  i_w_data = '0;
   logic              o_pooling_valid;
   logic [CI*OFB-1:0] o_pooling;
   logic [CI*WB-1:0]  o_weight;
   logic              o_first;
   logic              o_last;
   logic [1:0]        o_filter_idx;
   logic              o_busy;
   logic              o_overflow;

   stage3_pool_streamer dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .i_pool_valid    (i_pool_valid),
      .i_pool_data     (i_pool_data),
      .o_pool_ready    (o_pool_ready),
      .o_w_addr        (o_w_addr),
      .i_w_data        (i_w_data),
      .o_pooling_valid (o_pooling_valid),
      .o_pooling       (o_pooling),
      .o_weight        (o_weight),
      .o_first         (o_first),
      .o_last          (o_last),
      .o_filter_idx    (o_filter_idx),
      .o_busy          (o_busy),
      .o_overflow      (o_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pool;
      logic [31:0] w;
      logic        first;
      logic        last;
      logic [1:0]  fidx;
      int          stamp;
   } beat_t;

   beat_t       beats[$];
   logic [AW-1:0] addrs[$];
   logic [31:0] exp_vecs[$];
   int cyc = 0;
   int stray = 0;
   int errors = 0;
   int checks = 0;
   int last_acc = 0;

   // Weight ROM: every lane holds its own address, data one cycle after the address.
   always @(posedge clk) i_w_data <= {CI{8'(o_w_addr)}};
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_pooling_valid)
         beats.push_back('{pool: o_pooling, w: o_weight, first: o_first, last: o_last,
                           fidx: o_filter_idx, stamp: cyc});
      if (o_busy)
         addrs.push_back(o_w_addr);
      if (!o_pooling_valid && (o_first || o_last))
         stray++;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Beat i of the replay: frame i/FB, filter k, position p, ROM address = k*POS+p.
   function automatic logic [127:0] exp_beat(input int i);
      int f, m, k, p;
      logic [7:0] a;
      f = i / FB;
      m = i % FB;
      k = m / POS;
      p = m % POS;
      a = 8'(m);
      return {54'd0, exp_vecs[f*POS + p], {CI{a}}, (p == 0), (p == POS-1), 2'(k), 6'(m)};
   endfunction

   task automatic send(input logic [31:0] v, input bit honor_ready, output bit was_ready);
      int n;
      @(negedge clk);
      was_ready = o_pool_ready;
      if (honor_ready) begin
         n = 0;
         while (!o_pool_ready && n < 300) begin
            i_pool_valid = 1'b0;
            @(negedge clk);
            n++;
         end
         if (n > 0) check("ready_wait_bound", 128'(n < 300), 128'd1);
      end
      i_pool_valid = 1'b1;
      i_pool_data  = v;
      last_acc     = cyc + 1;
   endtask

   task automatic idle_in();
      @(negedge clk);
      i_pool_valid = 1'b0;
      i_pool_data  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_pool_valid = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      beats.delete();
      addrs.delete();
      exp_vecs.delete();
   endtask

   task automatic compare_stream(input string tag, input int first_stamp);
      int total, n, gaps;
      logic [5:0] a;
      total = (exp_vecs.size() / POS) * FB;
      n = 0;
      while (beats.size() < total && n < total + 500) begin
         @(negedge clk);
         n++;
      end
      repeat (8) @(negedge clk);
      check({tag, "_count"}, 128'(beats.size()), 128'(total));
      if (first_stamp >= 0 && beats.size() > 0)
         check({tag, "_latency"}, 128'(beats[0].stamp), 128'(first_stamp));
      gaps = 0;
      for (int i = 1; i < beats.size(); i++)
         if (beats[i].stamp != beats[i-1].stamp + 1) gaps++;
      check({tag, "_gaps"}, 128'(gaps), 128'd0);
      for (int i = 0; i < total && i < beats.size(); i++) begin
         a = (i < addrs.size()) ? addrs[i] : 6'bx;
         check($sformatf("%s_beat%0d", tag, i),
               {54'd0, beats[i].pool, beats[i].w, beats[i].first, beats[i].last,
                beats[i].fidx, a},
               exp_beat(i));
      end
   endtask

   initial begin
      bit wr;
      int drops;
      int first16;
      int prod;
      int n;
      logic [31:0] v;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready",   128'(o_pool_ready),    128'd1);
      check("rst_valid",   128'(o_pooling_valid), 128'd0);
      check("rst_pooling", 128'(o_pooling),       128'd0);
      check("rst_first",   128'(o_first),         128'd0);
      check("rst_last",    128'(o_last),          128'd0);
      check("rst_fidx",    128'(o_filter_idx),    128'd0);
      check("rst_busy",    128'(o_busy),          128'd0);
      check("rst_ovf",     128'(o_overflow),      128'd0);
      check("rst_waddr",   128'(o_w_addr),        128'd0);
      check("rst_weight",  128'(o_weight),        128'd0);
      reset_n = 1'b1;

      // Single frame, every channel = p+1
      drops = 0;
      for (int p = 0; p < POS; p++) begin
         v = {CI{8'(p + 1)}};
         send(v, 1'b1, wr);
         if (!wr) drops++;
         exp_vecs.push_back(v);
      end
      idle_in();
      check("single_ready_steady", 128'(drops), 128'd0);
      compare_stream("single", last_acc + 2);
      check("single_ovf", 128'(o_overflow), 128'd0);

      // Three random frames back-to-back, honoring ready
      do_reset();
      drops = 0;
      first16 = 0;
      for (int i = 0; i < 3*POS; i++) begin
         v = $urandom;
         send(v, 1'b1, wr);
         if (i < 2*POS && !wr) drops++;
         if (i == 2*POS) check("three_ready_drop", 128'(wr), 128'd0);
         if (i == POS-1) first16 = last_acc;
         exp_vecs.push_back(v);
      end
      idle_in();
      check("three_ready_early", 128'(drops), 128'd0);
      compare_stream("three", first16 + 2);
      check("three_ovf", 128'(o_overflow), 128'd0);

      // Weight pairing: feature -3 at p=5 meets ROM word 5 on filter 0
      do_reset();
      for (int p = 0; p < POS; p++) begin
         v = (p == 5) ? 32'hFDFD_FDFD : $urandom;
         send(v, 1'b1, wr);
         exp_vecs.push_back(v);
      end
      idle_in();
      compare_stream("weight", last_acc + 2);
      if (beats.size() > 5) begin
         for (int c = 0; c < CI; c++) begin
            prod = $signed(beats[5].pool[c*8 +: 8]) * $signed(beats[5].w[c*8 +: 8]);
            check($sformatf("weight_prod_lane%0d", c), 128'(prod), 128'(-15));
         end
      end

      // Ignore ready: 40 vectors at full rate, only the first two frames fit
      do_reset();
      for (int i = 0; i < 40; i++) begin
         v = $urandom;
         send(v, 1'b0, wr);
         if (i < 2*POS) exp_vecs.push_back(v);
      end
      idle_in();
      check("ignore_ovf", 128'(o_overflow), 128'd1);
      compare_stream("ignore", -1);

      // Reset in the middle of streaming
      do_reset();
      for (int p = 0; p < POS; p++) begin
         v = $urandom;
         send(v, 1'b1, wr);
         exp_vecs.push_back(v);
      end
      idle_in();
      n = 0;
      while (beats.size() < 20 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("mid_reached_beat20", 128'(n < 200), 128'd1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("mid_valid",   128'(o_pooling_valid), 128'd0);
      check("mid_pooling", 128'(o_pooling),       128'd0);
      check("mid_first",   128'(o_first),         128'd0);
      check("mid_last",    128'(o_last),          128'd0);
      check("mid_fidx",    128'(o_filter_idx),    128'd0);
      check("mid_waddr",   128'(o_w_addr),        128'd0);
      check("mid_busy",    128'(o_busy),          128'd0);
      check("mid_ready",   128'(o_pool_ready),    128'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      beats.delete();
      addrs.delete();
      exp_vecs.delete();
      for (int p = 0; p < POS; p++) begin
         v = $urandom;
         send(v, 1'b1, wr);
         exp_vecs.push_back(v);
      end
      idle_in();
      compare_stream("after_reset", last_acc + 2);

      // Partial frame produces nothing
      do_reset();
      for (int p = 0; p < 7; p++) begin
         v = $urandom;
         send(v, 1'b1, wr);
      end
      idle_in();
      repeat (40) @(negedge clk);
      check("partial_beats", 128'(beats.size()), 128'd0);
      check("partial_issues", 128'(addrs.size()), 128'd0);
      check("partial_busy", 128'(o_busy), 128'd0);
      check("partial_ready", 128'(o_pool_ready), 128'd1);

      check("flags_outside_valid", 128'(stray), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stage3_pool_streamer.md
# stage3_pool_streamer

Ping-pong frame buffer and sequencer that drives the stage-3 kernel's `i_pooling_valid` / `i_pooling` / `i_weight` inputs. It captures one stage-2 pooled frame of POS channel-vectors, then replays that frame once per output filter. On each beat it pairs every vector with the matching weight word fetched from an external weight ROM. It sits between the stage-2 max-pool output and the stage-3 kernel and marks accumulation groups for the downstream per-filter accumulator.

## Interface
Parameters:
- CI, `CI, input channels per vector
- OF_BW, `OF_BW, bits per pooled feature (signed)
- W_BW, `W_BW, bits per weight (signed)
- POS, 16, pooled positions per frame
- CO, 4, output filters; each frame is replayed CO times
- AW, $clog2(CO*POS), weight ROM address width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- i_pool_valid  in  1  upstream vector valid
- i_pool_data  in  CI*OF_BW  upstream vector, channel c at [c*OF_BW +: OF_BW]
- o_pool_ready  out  1  write bank has space
- o_w_addr  out  AW  weight ROM address, = k*POS + p
- i_w_data  in  CI*W_BW  ROM data, valid one cycle after o_w_addr
- o_pooling_valid  out  1  kernel input valid
- o_pooling  out  CI*OF_BW  buffered vector
- o_weight  out  CI*W_BW  combinational passthrough of i_w_data
- o_first  out  1  beat p==0 of a filter group
- o_last  out  1  beat p==POS-1 of a filter group
- o_filter_idx  out  $clog2(CO)  filter k of the current beat
- o_busy  out  1  FSM in S_RUN
- o_overflow  out  1  sticky: a vector arrived while o_pool_ready was 0

## Operation
- Storage: two banks of POS×(CI*OF_BW) with synchronous read. Flags bank_full[1:0], wr_bank, wr_ptr, rd_bank.
- Write side: accept when i_pool_valid & o_pool_ready. The vector goes to bank[wr_bank][wr_ptr] and wr_ptr increments. On the accept at wr_ptr==POS-1: set bank_full[wr_bank], toggle wr_bank, clear wr_ptr.
- o_pool_ready = !bank_full[wr_bank].
- If i_pool_valid arrives while o_pool_ready is 0, the vector is dropped and o_overflow sets. It clears only on reset.
- FSM S_IDLE: if bank_full[rd_bank], go to S_RUN with k=0, p=0.
- FSM S_RUN: each cycle, issue a read of bank[rd_bank][p] and drive o_w_addr=k*POS+p. Then advance p, wrapping to 0 and incrementing k.
  - On the issue with k==CO-1 and p==POS-1: clear bank_full[rd_bank] and toggle rd_bank.
  - Next state is S_RUN if the other bank is already full (no bubble); otherwise S_IDLE.
- One pipeline register stage carries the issue-valid, p==0, p==POS-1 and k to the outputs, aligned with the buffer read data and i_w_data.
- Simultaneous events:
  - A release of bank A and a fill of bank B in the same cycle both take effect.
  - A release and a fill of the same bank in the same cycle cannot occur, because the write side never targets a full bank.
  - The write side may refill the bank just released starting the cycle after the release.
- No backpressure from the kernel. Beats leave at one per cycle.

## Timing
- Reset values: all outputs 0, except o_pool_ready=1. FSM goes to S_IDLE; bank_full, wr_ptr, wr_bank and rd_bank all clear. A partially written or partially streamed frame is discarded.
- First o_pooling_valid comes 2 cycles after the clock edge that accepts a frame's final vector, when the FSM is idle: one cycle for S_IDLE→S_RUN issue, one cycle of read latency.
- Each frame produces exactly CO*POS contiguous valid beats.
- Back-to-back frames stream with no gap.
- o_first and o_last are valid only when o_pooling_valid is 1 and are 0 otherwise.
- With POS==1, o_first and o_last are both asserted on every beat.
- Downstream must delay o_first, o_last and o_filter_idx by the kernel's 2-cycle latency to align them with o_kernel.

## Structure
- CI, OF_BW, W_BW come from stage3_defines_cnn_core.vh.
- Add `S3_POS and `S3_CO to the same header so the kernel, ROM and accumulator agree.
- One sub-module, stage3_pingpong_ram: two banks, one write port, one synchronous read port, bank-select inputs.
- The FSM and the counters live in the top level.

## Test plan
- Single frame (POS=16, CO=4): write 16 vectors with every channel = p+1 at full rate. Expect o_pool_ready to stay 1 and 64 contiguous beats starting 2 cycles after the 16th accept.
  - Beat n carries o_pooling = (n%16)+1 and o_w_addr = n in the issue cycle.
  - o_first on beats 0/16/32/48, o_last on beats 15/31/47/63, o_filter_idx = n/16.
- Three frames back-to-back at full rate: o_pool_ready drops after the 32nd accept and returns 1 cycle after bank 0 is released. Output is 192 beats with no gap and o_overflow stays 0.
- Ignore ready: drive 40 vectors unconditionally. Expect o_overflow=1, and the dropped vectors never appear on o_pooling.
- Weight check: ROM content = address; a signed feature of -3 paired with weight 5 yields kernel product -15 on that lane.
- Reset mid-stream: assert reset_n=0 at beat 20. All outputs go to 0 immediately and o_pool_ready returns to 1. A new frame then streams from k=0, p=0.
- Partial frame: write 7 vectors and hold. Expect no output and o_busy=0.
